// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write scheduler.
//   state_t : scheduler mode (clearing the file, or running normal arbitration)
//   grant_t : identifies which requester won the most recent accepted transfer
package regfile_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef enum logic {
        GNT_WB  = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req        : request vector, bit 0 = writeback, bit 1 = debug/loader
//   last_grant : winner of the previous accepted transfer (held by the parent)
//   gnt        : one-hot grant, same bit order as req; all zero when idle
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the requester that did not
    // win last time gets the port.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the register file. Shares the single write port
// between the writeback stage and a debug/loader requester, and clears the
// whole file to zero after reset or on clear_req.
//   clk, rst                     : clock and asynchronous active-high reset
//   wb_valid/wb_wn/wb_wd         : writeback request, wb_ready accepts it
//   dbg_valid/dbg_wn/dbg_wd      : debug request, dbg_ready accepts it
//   clear_req                    : pulse that restarts the clear sequence
//   rf_we/rf_wn/rf_wd            : registered RegWrite/wn/wd for the file
//   init_done                    : high once a clear sequence has finished
//   drop_cnt                     : saturating count of accepted writes to r0
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_wn,
    input  logic [DW-1:0] wb_wd,
    output logic          wb_ready,
    input  logic          dbg_valid,
    input  logic [AW-1:0] dbg_wn,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_ready,
    input  logic          clear_req,
    output logic          rf_we,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_wd,
    output logic          init_done,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          rf_we_q;
    logic [AW-1:0] rf_wn_q;
    logic [DW-1:0] rf_wd_q;
    logic          init_done_q;
    grant_t        last_grant_q;
    logic [7:0]    drop_cnt_q;

    logic [1:0]    gnt;
    logic          portOpen;
    logic          bothIdle;
    logic          wbFire;
    logic          dbgFire;
    logic          anyFire;
    logic [AW-1:0] selWn_d;
    logic [DW-1:0] selWd_d;
    logic [7:0]    drop_cnt_d;

    rr_arb2 u_arb (
        .req        ({dbg_valid, wb_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    // The port is only offered in RUN, and a clear request closes it for
    // that cycle so nothing slips in just before the clear begins. With no
    // requests both readys are raised; that is harmless since nothing
    // transfers without a valid.
    always_comb begin
        portOpen   = (state_q == RUN) && !clear_req;
        bothIdle   = !wb_valid && !dbg_valid;
        wb_ready   = portOpen && (gnt[0] || bothIdle);
        dbg_ready  = portOpen && (gnt[1] || bothIdle);
        wbFire     = wb_valid && wb_ready;
        dbgFire    = dbg_valid && dbg_ready;
        anyFire    = wbFire || dbgFire;
        selWn_d    = dbgFire ? dbg_wn : wb_wn;
        selWd_d    = dbgFire ? dbg_wd : wb_wd;
        drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end

    // Scheduler FSM with registered write-port outputs. In CLEAR every
    // register gets a zero write in index order; in RUN the accepted
    // request is forwarded one cycle later, except that writes to r0 are
    // swallowed and counted instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            rf_we_q      <= 1'b0;
            rf_wn_q      <= '0;
            rf_wd_q      <= '0;
            init_done_q  <= 1'b0;
            last_grant_q <= GNT_DBG;
            drop_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rf_we_q <= 1'b1;
                    rf_wn_q <= cnt_q;
                    rf_wd_q <= '0;
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state_q     <= CLEAR;
                        cnt_q       <= '0;
                        init_done_q <= 1'b0;
                        rf_we_q     <= 1'b0;
                    end else if (anyFire) begin
                        rf_wn_q      <= selWn_d;
                        rf_wd_q      <= selWd_d;
                        rf_we_q      <= (selWn_d != '0);
                        last_grant_q <= dbgFire ? GNT_DBG : GNT_WB;
                        if (selWn_d == '0) begin
                            drop_cnt_q <= drop_cnt_d;
                        end
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wn     = rf_wn_q;
    assign rf_wd     = rf_wd_q;
    assign init_done = init_done_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Testbench for regfile_write_sched. A transaction-level model predicts the
// write port and ready behaviour; expectations are queued by the driver and
// popped by independent monitors. A small register-file memory is attached
// to the write port so read-port values can be checked too.
module tb_regfile_write_sched;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic [AW-1:0] wb_wn;
    logic [DW-1:0] wb_wd;
    logic          wb_ready;
    logic          dbg_valid;
    logic [AW-1:0] dbg_wn;
    logic [DW-1:0] dbg_wd;
    logic          dbg_ready;
    logic          clear_req;
    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_wd;
    logic          init_done;
    logic [7:0]    drop_cnt;

    regfile_write_sched #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_wn     (wb_wn),
        .wb_wd     (wb_wd),
        .wb_ready  (wb_ready),
        .dbg_valid (dbg_valid),
        .dbg_wn    (dbg_wn),
        .dbg_wd    (dbg_wd),
        .dbg_ready (dbg_ready),
        .clear_req (clear_req),
        .rf_we     (rf_we),
        .rf_wn     (rf_wn),
        .rf_wd     (rf_wd),
        .init_done (init_done),
        .drop_cnt  (drop_cnt)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wn;
        logic [DW-1:0] wd;
        logic          initDone;
        logic [7:0]    drop;
    } expOut_t;

    typedef struct packed {
        logic wbR;
        logic dbgR;
    } expRdy_t;

    expOut_t outQ[$];
    expRdy_t rdyQ[$];

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state, expressed in terms of the behaviour only
    bit            mClearing;
    int            mCnt;
    bit            mInitDone;
    bit            mLastDbg;
    int            mDrop;
    bit            mWe;
    logic [AW-1:0] mWn;
    logic [DW-1:0] mWd;
    logic [DW-1:0] expMem [NREG];
    logic [DW-1:0] rfMem  [NREG];

    bit            holdWb;
    logic [AW-1:0] holdWbN;
    logic [DW-1:0] holdWbD;
    bit            holdDbg;
    logic [AW-1:0] holdDbgN;
    logic [DW-1:0] holdDbgD;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdPort(input logic [AW-1:0] rs);
        return (rf_we && rf_wn == rs) ? rf_wd : rfMem[rs];
    endfunction

    task automatic modelReset();
        mClearing = 1'b1;
        mCnt      = 0;
        mInitDone = 1'b0;
        mLastDbg  = 1'b1;
        mDrop     = 0;
        mWe       = 1'b0;
        mWn       = '0;
        mWd       = '0;
        holdWb    = 1'b0;
        holdDbg   = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the readys for this cycle and the
    // write-port outputs after the coming edge, and queue both.
    task automatic applyStimulus(input bit wbV, input logic [AW-1:0] wbN, input logic [DW-1:0] wbD,
                                 input bit dbgV, input logic [AW-1:0] dbgN, input logic [DW-1:0] dbgD,
                                 input bit clr);
        bit            wbR;
        bit            dbgR;
        bit            win;
        logic [AW-1:0] wn;
        logic [DW-1:0] wd;
        expOut_t       eo;
        expRdy_t       er;
        @(negedge clk);
        if (holdWb) begin
            wbV = 1'b1; wbN = holdWbN; wbD = holdWbD;
        end
        if (holdDbg) begin
            dbgV = 1'b1; dbgN = holdDbgN; dbgD = holdDbgD;
        end
        wb_valid  = wbV;  wb_wn  = wbN;  wb_wd  = wbD;
        dbg_valid = dbgV; dbg_wn = dbgN; dbg_wd = dbgD;
        clear_req = clr;
        wbR  = 1'b0;
        dbgR = 1'b0;
        if (mClearing) begin
            mWe = 1'b1;
            mWn = mCnt[AW-1:0];
            mWd = '0;
            expMem[mCnt] = '0;
            mCnt++;
            if (mCnt == NREG) begin
                mClearing = 1'b0;
                mInitDone = 1'b1;
                mCnt      = 0;
            end
        end else if (clr) begin
            mClearing = 1'b1;
            mCnt      = 0;
            mInitDone = 1'b0;
            mWe       = 1'b0;
        end else if (!wbV && !dbgV) begin
            wbR  = 1'b1;
            dbgR = 1'b1;
            mWe  = 1'b0;
        end else begin
            if (wbV && dbgV) win = !mLastDbg;
            else             win = dbgV;
            mLastDbg = win;
            if (win) dbgR = 1'b1;
            else     wbR  = 1'b1;
            wn  = win ? dbgN : wbN;
            wd  = win ? dbgD : wbD;
            mWn = wn;
            mWd = wd;
            if (wn != '0) begin
                mWe = 1'b1;
                expMem[wn] = wd;
            end else begin
                mWe = 1'b0;
                if (mDrop < 255) mDrop++;
            end
        end
        holdWb   = wbV && !wbR;
        holdWbN  = wbN;
        holdWbD  = wbD;
        holdDbg  = dbgV && !dbgR;
        holdDbgN = dbgN;
        holdDbgD = dbgD;
        er.wbR  = wbR;
        er.dbgR = dbgR;
        rdyQ.push_back(er);
        eo.we       = mWe;
        eo.wn       = mWn;
        eo.wd       = mWd;
        eo.initDone = mInitDone;
        eo.drop     = 8'(mDrop);
        outQ.push_back(eo);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rf_we"},     32'(rf_we),     32'd0);
        checkOutput({tag, "_rf_wn"},     32'(rf_wn),     32'd0);
        checkOutput({tag, "_rf_wd"},     32'(rf_wd),     32'd0);
        checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
        checkOutput({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
        checkOutput({tag, "_wb_ready"},  32'(wb_ready),  32'd0);
        checkOutput({tag, "_dbg_ready"}, 32'(dbg_ready), 32'd0);
    endtask

    // Register file attached to the write port
    always @(posedge clk) begin
        if (rf_we) rfMem[rf_wn] <= rf_wd;
    end

    // Output monitor: compares the registered write port after each edge
    always begin
        expOut_t e;
        @(posedge clk);
        #1;
        if (outQ.size() > 0) begin
            e = outQ.pop_front();
            checkOutput("rf_we",     32'(rf_we),     32'(e.we));
            checkOutput("rf_wn",     32'(rf_wn),     32'(e.wn));
            checkOutput("rf_wd",     32'(rf_wd),     32'(e.wd));
            checkOutput("init_done", 32'(init_done), 32'(e.initDone));
            checkOutput("drop_cnt",  32'(drop_cnt),  32'(e.drop));
        end
    end

    // Ready monitor: compares the combinational readys mid-cycle
    always begin
        expRdy_t r;
        @(negedge clk);
        #2;
        if (rdyQ.size() > 0) begin
            r = rdyQ.pop_front();
            checkOutput("wb_ready",  32'(wb_ready),  32'(r.wbR));
            checkOutput("dbg_ready", 32'(dbg_ready), 32'(r.dbgR));
        end
    end

    // A stalled requester must keep its request unchanged
    logic          prevWbStall;
    logic          prevDbgStall;
    logic [AW-1:0] prevWbN;
    logic [DW-1:0] prevWbD;
    logic [AW-1:0] prevDbgN;
    logic [DW-1:0] prevDbgD;
    always @(posedge clk) begin
        if (rst) begin
            prevWbStall  <= 1'b0;
            prevDbgStall <= 1'b0;
        end else begin
            #1;
            if (prevWbStall)
                assert (wb_valid && wb_wn == prevWbN && wb_wd == prevWbD)
                    else $error("[TB] writeback request changed while stalled");
            if (prevDbgStall)
                assert (dbg_valid && dbg_wn == prevDbgN && dbg_wd == prevDbgD)
                    else $error("[TB] debug request changed while stalled");
        end
    end
    always @(negedge clk) begin
        #4;
        prevWbStall  <= !rst && wb_valid && !wb_ready;
        prevDbgStall <= !rst && dbg_valid && !dbg_ready;
        prevWbN      <= wb_wn;
        prevWbD      <= wb_wd;
        prevDbgN     <= dbg_wn;
        prevDbgD     <= dbg_wd;
    end

    initial begin
        wb_valid  = 1'b0; wb_wn  = '0; wb_wd  = '0;
        dbg_valid = 1'b0; dbg_wn = '0; dbg_wd = '0;
        clear_req = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            expMem[i] = 32'hDEAD_BEEF;
            rfMem[i]  = 32'hDEAD_BEEF;
        end
        modelReset();

        // Reset state, then release mid-cycle
        #5;
        checkResetValues("reset");
        @(posedge clk);
        @(posedge clk);
        #5;
        rst = 1'b0;

        // Initial clear sequence plus one idle RUN cycle
        repeat (NREG + 1) idleCycle();

        // Contention: grants alternate starting with writeback
        repeat (10) applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0);

        // Writes to register 0 are dropped and counted, saturating
        repeat (300) applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0);
        idleCycle();
        settle();
        checkOutput("rd1_r0", rdPort(5'd0), expMem[0]);
        checkOutput("drop_sat", 32'(drop_cnt), 32'd255);

        // Clear request while debug is valid; the earlier write still lands
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b1);
        repeat (NREG + 2) idleCycle();
        settle();
        checkOutput("rd_r7_after_clear", rdPort(5'd7), expMem[7]);
        checkOutput("rd_r9_after_clear", rdPort(5'd9), expMem[9]);

        // Asynchronous reset part-way through a clear (after 17 writes)
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        repeat (17) idleCycle();
        settle();
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        #1;
        rst = 1'b0;
        modelReset();
        repeat (NREG + 1) idleCycle();

        // Single debug requester
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd31, 32'h1234, 1'b0);
        settle();
        checkOutput("rd2_r31", rdPort(5'd31), expMem[31]);

        // Randomized traffic with occasional clear requests
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          ($urandom_range(0, 39) == 0));
        end
        repeat (NREG + 3) idleCycle();
        settle();
        for (int i = 0; i < NREG; i++) begin
            checkOutput($sformatf("rd_final_r%0d", i), rdPort(5'(i)), expMem[i]);
        end

        #5;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
